// File: rtl/xintf_dsp_responder_pkg.sv
// rtl/xintf_dsp_responder_pkg.sv - shared types and constants for the XINTF DSP responder
package xintf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RD_HOLD,
    ST_WR_COMMIT,
    ST_RELEASE
  } state_t;

  localparam int SYNC_STAGES      = 2;
  localparam int DEF_ADDR_WIDTH   = 9;
  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_RD_LAST_ADDR = 42;
  localparam int DEF_WR_LAST_ADDR = 9;

endpackage

// File: rtl/xintf_dsp_responder_if.sv
// rtl/xintf_dsp_responder_if.sv - DSP pad, DPBRAM port and status signals of the responder
interface xintf_dsp_responder_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16
);
  logic                  i_xintf_zcs_n;
  logic                  i_xintf_rd_n;
  logic                  i_xintf_we_n;
  logic [ADDR_WIDTH-1:0] i_xintf_addr;
  logic [DATA_WIDTH-1:0] i_xintf_data;
  logic [DATA_WIDTH-1:0] o_xintf_data;
  logic                  o_xintf_data_oe;
  logic [ADDR_WIDTH-1:0] o_zd_addr;
  logic                  o_zd_ce;
  logic [DATA_WIDTH-1:0] i_zd_dout;
  logic [ADDR_WIDTH-1:0] o_dz_addr;
  logic                  o_dz_ce;
  logic                  o_dz_we;
  logic [DATA_WIDTH-1:0] o_dz_din;
  logic                  o_rd_frame_done;
  logic                  o_wr_frame_done;
  logic                  o_bus_err;
  logic                  i_err_clr;

  modport slave (
    input  i_xintf_zcs_n, i_xintf_rd_n, i_xintf_we_n, i_xintf_addr, i_xintf_data,
    input  i_zd_dout, i_err_clr,
    output o_xintf_data, o_xintf_data_oe, o_zd_addr, o_zd_ce,
    output o_dz_addr, o_dz_ce, o_dz_we, o_dz_din,
    output o_rd_frame_done, o_wr_frame_done, o_bus_err
  );

  modport master (
    output i_xintf_zcs_n, i_xintf_rd_n, i_xintf_we_n, i_xintf_addr, i_xintf_data,
    output i_zd_dout, i_err_clr,
    input  o_xintf_data, o_xintf_data_oe, o_zd_addr, o_zd_ce,
    input  o_dz_addr, o_dz_ce, o_dz_we, o_dz_din,
    input  o_rd_frame_done, o_wr_frame_done, o_bus_err
  );
endinterface

// File: rtl/xintf_dsp_responder_sync.sv
// rtl/xintf_dsp_responder_sync.sv - multi-flop synchronizer for the asynchronous DSP strobes
module xintf_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] sr;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) sr <= '0;
    else        sr <= {sr[STAGES-2:0], i_d};
  end

  assign o_q = sr[STAGES-1];
endmodule

// File: rtl/xintf_dsp_responder.sv
// rtl/xintf_dsp_responder.sv - turns DSP XINTF strobes into single DPBRAM accesses
module xintf_dsp_responder
  import xintf_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int RAM_LAT      = 1,
  parameter int RD_LAST_ADDR = DEF_RD_LAST_ADDR,
  parameter int WR_LAST_ADDR = DEF_WR_LAST_ADDR
) (
  input logic i_clk,
  input logic i_rst,
  xintf_dsp_responder_if.slave bus
);
  localparam logic [ADDR_WIDTH-1:0] RD_LAST = ADDR_WIDTH'(RD_LAST_ADDR);
  localparam logic [ADDR_WIDTH-1:0] WR_LAST = ADDR_WIDTH'(WR_LAST_ADDR);

  state_t                state, state_n;
  logic                  s_rd, s_wr;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [1:0]            wait_cnt;
  logic [1:0]            prime_cnt;
  logic                  seen_idle;
  logic ld_addr, ld_wdata, rd_oor, set_err, zd_req, rd_cap, rd_release, wr_commit;

  xintf_sync #(.STAGES(SYNC_STAGES)) u_sync_rd (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_d(~bus.i_xintf_zcs_n & ~bus.i_xintf_rd_n), .o_q(s_rd)
  );
  xintf_sync #(.STAGES(SYNC_STAGES)) u_sync_wr (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_d(~bus.i_xintf_zcs_n & ~bus.i_xintf_we_n), .o_q(s_wr)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    ld_addr    = 1'b0;
    ld_wdata   = 1'b0;
    rd_oor     = 1'b0;
    set_err    = 1'b0;
    zd_req     = 1'b0;
    rd_cap     = 1'b0;
    rd_release = 1'b0;
    wr_commit  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (seen_idle) begin
          if (s_rd && s_wr) begin
            set_err = 1'b1;
            state_n = ST_RELEASE;
          end else if (s_rd) begin
            ld_addr = 1'b1;
            if (bus.i_xintf_addr <= RD_LAST) begin
              state_n = ST_RD_REQ;
            end else begin
              rd_oor  = 1'b1;
              state_n = ST_RD_HOLD;
            end
          end else if (s_wr) begin
            ld_addr  = 1'b1;
            ld_wdata = 1'b1;
            state_n  = ST_WR_COMMIT;
          end
        end
      end
      ST_RD_REQ: begin
        zd_req  = 1'b1;
        state_n = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (wait_cnt == 2'(RAM_LAT)) begin
          rd_cap  = 1'b1;
          state_n = ST_RD_HOLD;
        end
      end
      ST_RD_HOLD: begin
        if (!s_rd) begin
          rd_release = 1'b1;
          state_n    = ST_IDLE;
        end
      end
      ST_WR_COMMIT: begin
        wr_commit = 1'b1;
        state_n   = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!s_rd && !s_wr) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // The synchronizers read 0 straight out of reset, so "idle" only counts once they hold real pin state.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      prime_cnt <= '0;
      seen_idle <= 1'b0;
    end else begin
      if (prime_cnt != 2'(SYNC_STAGES)) prime_cnt <= prime_cnt + 2'd1;
      else if (!s_rd && !s_wr)          seen_idle <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      addr_q               <= '0;
      wdata_q              <= '0;
      wait_cnt             <= '0;
      bus.o_xintf_data     <= '0;
      bus.o_xintf_data_oe  <= 1'b0;
      bus.o_zd_addr        <= '0;
      bus.o_zd_ce          <= 1'b0;
      bus.o_dz_addr        <= '0;
      bus.o_dz_ce          <= 1'b0;
      bus.o_dz_we          <= 1'b0;
      bus.o_dz_din         <= '0;
      bus.o_rd_frame_done  <= 1'b0;
      bus.o_wr_frame_done  <= 1'b0;
      bus.o_bus_err        <= 1'b0;
    end else begin
      if (ld_addr)  addr_q  <= bus.i_xintf_addr;
      if (ld_wdata) wdata_q <= bus.i_xintf_data;

      wait_cnt <= (state == ST_RD_WAIT) ? wait_cnt + 2'd1 : 2'd0;

      if (zd_req) begin
        bus.o_zd_addr <= addr_q;
        bus.o_zd_ce   <= 1'b1;
      end else if (rd_cap) begin
        bus.o_zd_ce   <= 1'b0;
      end

      if (rd_cap)      bus.o_xintf_data <= bus.i_zd_dout;
      else if (rd_oor) bus.o_xintf_data <= '0;

      if (rd_cap || rd_oor) bus.o_xintf_data_oe <= 1'b1;
      else if (rd_release)  bus.o_xintf_data_oe <= 1'b0;

      bus.o_rd_frame_done <= rd_release && (addr_q == RD_LAST);

      bus.o_dz_ce <= wr_commit && (addr_q <= WR_LAST);
      bus.o_dz_we <= wr_commit && (addr_q <= WR_LAST);
      if (wr_commit) begin
        bus.o_dz_addr <= addr_q;
        bus.o_dz_din  <= wdata_q;
      end
      bus.o_wr_frame_done <= bus.o_dz_we && (bus.o_dz_addr == WR_LAST);

      if (set_err)            bus.o_bus_err <= 1'b1;
      else if (bus.i_err_clr) bus.o_bus_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_xintf_dsp_responder.sv
// tb/tb_xintf_dsp_responder.sv - self-checking bench for xintf_dsp_responder
module tb_xintf_dsp_responder;
  localparam int AW = 9;
  localparam int DW = 16;
  localparam int RD_LAST = 42;
  localparam int WR_LAST = 9;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;

  xintf_dsp_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  xintf_dsp_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LAT(1),
    .RD_LAST_ADDR(RD_LAST), .WR_LAST_ADDR(WR_LAST)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus(bus)
  );

  always #5 i_clk = ~i_clk;

  logic [DW-1:0] zd_mem [0:511];
  logic [DW-1:0] dz_mem [0:511];
  logic [DW-1:0] exp_dz [0:511];

  always @(posedge i_clk) if (bus.o_zd_ce) bus.i_zd_dout <= zd_mem[bus.o_zd_addr];

  int zd_bursts = 0, dz_we_cnt = 0, rd_fd_cnt = 0, wr_fd_cnt = 0;
  logic ce_prev = 1'b0;
  logic [AW-1:0] last_zd_addr = '0, last_dz_addr = '0;
  logic [DW-1:0] last_dz_din = '0;

  always @(negedge i_clk) begin
    if (bus.o_zd_ce && !ce_prev) begin
      zd_bursts++;
      last_zd_addr = bus.o_zd_addr;
    end
    ce_prev = bus.o_zd_ce;
    if (bus.o_dz_we && bus.o_dz_ce) begin
      dz_we_cnt++;
      last_dz_addr = bus.o_dz_addr;
      last_dz_din  = bus.o_dz_din;
      dz_mem[bus.o_dz_addr] = bus.o_dz_din;
    end
    if (bus.o_rd_frame_done) rd_fd_cnt++;
    if (bus.o_wr_frame_done) wr_fd_cnt++;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_read(input int a);
    return (a <= RD_LAST) ? zd_mem[a] : '0;
  endfunction

  task automatic dsp_read(input int a, input int len, output logic [DW-1:0] d,
                          output int lat, output int rel);
    @(negedge i_clk);
    bus.i_xintf_addr  = AW'(a);
    bus.i_xintf_zcs_n = 1'b0;
    bus.i_xintf_rd_n  = 1'b0;
    lat = -1;
    for (int i = 1; i <= len; i++) begin
      @(negedge i_clk);
      if (lat < 0 && bus.o_xintf_data_oe) lat = i;
    end
    d = bus.o_xintf_data;
    bus.i_xintf_rd_n  = 1'b1;
    bus.i_xintf_zcs_n = 1'b1;
    rel = -1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge i_clk);
      if (rel < 0 && !bus.o_xintf_data_oe) rel = i;
    end
  endtask

  task automatic dsp_write(input int a, input logic [DW-1:0] d, input int len);
    @(negedge i_clk);
    bus.i_xintf_addr  = AW'(a);
    bus.i_xintf_data  = d;
    bus.i_xintf_zcs_n = 1'b0;
    bus.i_xintf_we_n  = 1'b0;
    repeat (len) @(negedge i_clk);
    bus.i_xintf_we_n  = 1'b1;
    bus.i_xintf_zcs_n = 1'b1;
    repeat (6) @(negedge i_clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    int lat, rel, b0, w0, rf0, wf0, n_rd_fd, n_wr_fd;

    bus.i_xintf_zcs_n = 1'b1;
    bus.i_xintf_rd_n  = 1'b1;
    bus.i_xintf_we_n  = 1'b1;
    bus.i_xintf_addr  = '0;
    bus.i_xintf_data  = '0;
    bus.i_err_clr     = 1'b0;
    for (int i = 0; i < 512; i++) begin
      zd_mem[i] = DW'($urandom);
      dz_mem[i] = '0;
      exp_dz[i] = '0;
    end
    zd_mem[5] = 16'hA55A;

    repeat (3) @(negedge i_clk);
    chk("rst_oe", bus.o_xintf_data_oe, 0);
    chk("rst_data", bus.o_xintf_data, 0);
    chk("rst_ports", {bus.o_zd_ce, bus.o_dz_ce, bus.o_dz_we}, 0);
    chk("rst_flags", {bus.o_rd_frame_done, bus.o_wr_frame_done, bus.o_bus_err}, 0);
    i_rst = 1'b1;
    repeat (6) @(negedge i_clk);

    b0 = zd_bursts;
    dsp_read(5, 10, d, lat, rel);
    chk("rd5_data", d, 16'hA55A);
    chk("rd5_latency_le6", (lat >= 1 && lat <= 6), 1);
    chk("rd5_bursts", zd_bursts - b0, 1);
    chk("rd5_zd_addr", last_zd_addr, 5);
    chk("rd5_release_le3", (rel >= 1 && rel <= 3), 1);

    w0 = dz_we_cnt; wf0 = wr_fd_cnt;
    dsp_write(9, 16'h1234, 8);
    exp_dz[9] = 16'h1234;
    chk("wr9_pulses", dz_we_cnt - w0, 1);
    chk("wr9_addr", last_dz_addr, 9);
    chk("wr9_din", last_dz_din, 16'h1234);
    chk("wr9_frame_done", wr_fd_cnt - wf0, 1);

    rf0 = rd_fd_cnt;
    dsp_read(42, 10, d, lat, rel);
    chk("rd42_data", d, exp_read(42));
    chk("rd42_frame_done", rd_fd_cnt - rf0, 1);

    b0 = zd_bursts; rf0 = rd_fd_cnt;
    dsp_read(43, 10, d, lat, rel);
    chk("rd43_data", d, 0);
    chk("rd43_no_ce", zd_bursts - b0, 0);
    chk("rd43_no_frame", rd_fd_cnt - rf0, 0);

    w0 = dz_we_cnt; wf0 = wr_fd_cnt;
    dsp_write(10, 16'hBEEF, 8);
    chk("wr10_dropped", dz_we_cnt - w0, 0);
    chk("wr10_no_frame", wr_fd_cnt - wf0, 0);

    b0 = zd_bursts; w0 = dz_we_cnt;
    @(negedge i_clk);
    bus.i_xintf_addr  = AW'(3);
    bus.i_xintf_zcs_n = 1'b0;
    bus.i_xintf_rd_n  = 1'b0;
    bus.i_xintf_we_n  = 1'b0;
    repeat (10) @(negedge i_clk);
    bus.i_xintf_rd_n  = 1'b1;
    bus.i_xintf_we_n  = 1'b1;
    bus.i_xintf_zcs_n = 1'b1;
    repeat (6) @(negedge i_clk);
    chk("both_no_access", (zd_bursts - b0) + (dz_we_cnt - w0), 0);
    chk("both_err_set", bus.o_bus_err, 1);
    repeat (5) @(negedge i_clk);
    chk("both_err_held", bus.o_bus_err, 1);
    bus.i_err_clr = 1'b1;
    @(negedge i_clk);
    bus.i_err_clr = 1'b0;
    @(negedge i_clk);
    chk("err_cleared", bus.o_bus_err, 0);

    @(negedge i_clk);
    bus.i_xintf_addr  = AW'(7);
    bus.i_xintf_zcs_n = 1'b0;
    bus.i_xintf_rd_n  = 1'b0;
    repeat (8) @(negedge i_clk);
    chk("midrd_oe_before", bus.o_xintf_data_oe, 1);
    #1 i_rst = 1'b0;
    #1 chk("midrd_oe_async", bus.o_xintf_data_oe, 0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    b0 = zd_bursts;
    repeat (12) @(negedge i_clk);
    chk("midrd_no_access", zd_bursts - b0, 0);
    chk("midrd_oe_low", bus.o_xintf_data_oe, 0);
    bus.i_xintf_rd_n  = 1'b1;
    bus.i_xintf_zcs_n = 1'b1;
    repeat (6) @(negedge i_clk);
    dsp_read(7, 10, d, lat, rel);
    chk("after_rst_read", d, exp_read(7));
    chk("after_rst_bursts", zd_bursts - b0, 1);

    b0 = zd_bursts; w0 = dz_we_cnt; rf0 = rd_fd_cnt; wf0 = wr_fd_cnt;
    n_rd_fd = 0; n_wr_fd = 0;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        int a;
        a = $urandom_range(RD_LAST, 0);
        if (a == RD_LAST) n_rd_fd++;
        dsp_read(a, 50, d, lat, rel);
        chk($sformatf("long_rd%0d_a%0d", i, a), d, exp_read(a));
      end else begin
        int a;
        logic [DW-1:0] wd;
        a  = $urandom_range(WR_LAST, 0);
        wd = DW'($urandom);
        if (a == WR_LAST) n_wr_fd++;
        exp_dz[a] = wd;
        dsp_write(a, wd, 50);
      end
    end
    chk("long_accesses", (zd_bursts - b0) + (dz_we_cnt - w0), 20);
    chk("long_rd_frames", rd_fd_cnt - rf0, n_rd_fd);
    chk("long_wr_frames", wr_fd_cnt - wf0, n_wr_fd);
    for (int a = 0; a <= WR_LAST; a++)
      chk($sformatf("dz_mem%0d", a), dz_mem[a], exp_dz[a]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/xintf_dsp_responder.md
# xintf_dsp_responder

FPGA-side responder for the DSP's XINTF external bus: turns asynchronous DSP read/write strobes into single-cycle accesses on the two XINTF DPBRAMs. DSP reads are served from the Zynq-to-DSP RAM (read port, address 1). DSP writes are committed to the DSP-to-Zynq RAM (write port, address 0). This is the DSP-facing end of the same DPBRAM pair the DSP handler writes and reads. Frame-complete pulses tell the core when the DSP has consumed the setpoint frame or delivered a status frame.

## Interface
Parameters:
- ADDR_WIDTH, 9, XINTF/DPBRAM address width
- DATA_WIDTH, 16, XINTF/DPBRAM data width
- RAM_LAT, 1, DPBRAM read latency in clocks (1..3)
- RD_LAST_ADDR, 42, last valid Zynq-to-DSP word (depth 43)
- WR_LAST_ADDR, 9, last valid DSP-to-Zynq word (depth 10)

Ports:
- i_clk  in  1  core clock, 200 MHz; one clock domain
- i_rst  in  1  reset, asynchronous, active-low
- i_xintf_zcs_n / i_xintf_rd_n / i_xintf_we_n  in  1 each  DSP chip select, read strobe, write strobe (async, active-low)
- i_xintf_addr  in  ADDR_WIDTH  DSP address
- i_xintf_data  in  DATA_WIDTH  DSP write data
- o_xintf_data  out  DATA_WIDTH  read data to pad
- o_xintf_data_oe  out  1  pad output enable
- o_zd_addr / o_zd_ce  out  ADDR_WIDTH / 1  Zynq-to-DSP RAM read port
- i_zd_dout  in  DATA_WIDTH  Zynq-to-DSP RAM read data
- o_dz_addr / o_dz_ce / o_dz_we / o_dz_din  out  ADDR_WIDTH / 1 / 1 / DATA_WIDTH  DSP-to-Zynq RAM write port
- o_rd_frame_done  out  1  one-clock pulse: DSP finished reading RD_LAST_ADDR
- o_wr_frame_done  out  1  one-clock pulse: DSP wrote WR_LAST_ADDR
- o_bus_err  out  1  sticky protocol error
- i_err_clr  in  1  clears o_bus_err

## Operation
- **Synchronization.** rd = ~zcs_n & ~rd_n and wr = ~zcs_n & ~we_n each pass a 2-flop synchronizer to give s_rd and s_wr. Address and data are sampled without synchronization, in the cycle the FSM leaves IDLE. The DSP holds them stable for the whole strobe (XINTF lead ≥ 1 clk).
- **FSM states:** IDLE, RD_REQ, RD_WAIT, RD_HOLD, WR_COMMIT, RELEASE.
- **IDLE**
  - s_rd only: latch address. If address ≤ RD_LAST_ADDR, go to RD_REQ; otherwise load o_xintf_data with 0 and go to RD_HOLD without any RAM access.
  - s_wr only: latch address and data, then go to WR_COMMIT.
  - s_rd and s_wr together: set o_bus_err, make no RAM access, go to RELEASE.
- **RD_REQ:** o_zd_addr and o_zd_ce = 1, then RD_WAIT for RAM_LAT cycles.
- **RD_WAIT end:** register i_zd_dout into o_xintf_data, set o_xintf_data_oe = 1, clear o_zd_ce, go to RD_HOLD.
- **RD_HOLD:** hold the data until s_rd = 0. Then oe = 0 and go to IDLE. o_rd_frame_done pulses at this exit if the latched address = RD_LAST_ADDR.
- **WR_COMMIT:** o_dz_ce = o_dz_we = 1 for exactly one clock, but only if address ≤ WR_LAST_ADDR (out-of-range writes are dropped). Then go to RELEASE. o_wr_frame_done pulses the clock after the commit if address = WR_LAST_ADDR.
- **RELEASE:** wait until s_rd = s_wr = 0, then go to IDLE.
- **One access per strobe.** Each strobe assertion yields at most one RAM access, however long the strobe lasts.
- **Error clear.** i_err_clr clears o_bus_err. If an error and a clear occur in the same clock, the error wins.

## Timing
- **Reset.** All outputs are 0: o_xintf_data = 0, oe = 0, all RAM ports idle, both frame pulses 0, o_bus_err = 0. FSM is in IDLE.
- **Reset released during an active strobe.** The block does not act on that strobe. A "seen idle" flag must observe s_rd = s_wr = 0 before the first access is accepted.
- **Reset asserted mid-read.** oe drops asynchronously.
- **Read latency.** From the pin strobe edge to valid o_xintf_data with oe = 1 is at most 2 (sync) + 1 (metastability) + 1 (RD_REQ) + RAM_LAT + 1 clocks, i.e. 6 clocks at RAM_LAT = 1. The DSP XINTF read active phase must be ≥ 7 clocks (35 ns).
- **Read release.** oe deasserts 2–3 clocks after rd_n rises.
- **Write.** The RAM write occurs 4–5 clocks after we_n falls. The DSP write active phase must be ≥ 5 clocks.
- **Back-to-back accesses.** A new strobe is accepted only after the previous one has been seen deasserted.

## Structure
- **Package xintf_pkg:** FSM state enum, SYNC_STAGES = 2, default last-address constants.
- **Sub-module xintf_sync:** 2-flop synchronizer with an asynchronous active-low reset value of 0, instantiated twice (rd, wr).
- **Top:** FSM, address/data latches, RAM-port registers, frame/error logic.

## Test plan
- **Read.** Preload ZD[5] = 16'hA55A. DSP read addr 5 with a 10-clock strobe → o_zd_addr = 5 with one ce burst; o_xintf_data = A55A, oe = 1 by clock 6; oe = 0 within 3 clocks of rd_n rising.
- **Write, frame done.** DSP write addr 9, data 16'h1234, 8-clock strobe → exactly one o_dz_we pulse with addr 9 and din 1234; one o_wr_frame_done pulse.
- **Boundary addresses.** Read addr 42 → o_rd_frame_done pulses once at release. Read addr 43 → data 0, no o_zd_ce. Write addr 10 → no o_dz_we.
- **Simultaneous strobes.** rd_n and we_n low together → no RAM access, o_bus_err = 1 and held; i_err_clr pulse → 0.
- **Reset mid-read.** Assert i_rst during RD_HOLD → oe = 0 immediately. Release reset with rd_n still low → no access until rd_n has risen and a fresh strobe arrives.
- **Long strobes.** 20 alternating reads and writes, each strobe 50 clocks → exactly 20 RAM accesses and correct data.
